dpram_access_ctrl: RTL
======================

# dpram_access_ctrl

Sequencer between the DE2-115 switch/button test front end and the on-chip dual-port RAM. Accepts single-shot read or write requests as edges on `RD`/`WR`, with the target address on `A` and write data on `DIn`. Executes each request on the internal RAM and returns read data on `DOut` with a level `Done` status for the front end's LEDs and seven-segment display. Requests are strictly serialized; requests that arrive while an access is in flight are dropped, not queued.

## Interface
- `ADDR_W`, 10: address width.
- `DATA_W`, 16: data width.
- `DEPTH`, 1024: implemented words; must satisfy 1 ≤ `DEPTH` ≤ 2^`ADDR_W`.
- `RD_LAT`, 2: RAM read latency in cycles; legal range 1..3.
- `clk` in 1: the only clock; all state changes on posedge.
- `ar` in 1: asynchronous, active-low reset.
- `A` in `ADDR_W`: request address; sampled on the accept edge.
- `DIn` in `DATA_W`: write data; sampled on the accept edge.
- `RD` in 1: read request, level; its rising edge is the request.
- `WR` in 1: write request, level; its rising edge is the request.
- `DOut` out `DATA_W`: last read data; holds its value until the next read completes.
- `Done` out 1: level; set when an access completes, cleared when the next request is accepted.
- `Busy` out 1: high from the accept edge until the `Done` edge.
- `Err` out 1: last request rejected (collision or out of range); cleared when the next request is accepted.

## Operation
- Edge detect: registered `rd_q`/`wr_q`, updated every cycle regardless of state.
  - `rd_rise = RD & ~rd_q`; `wr_rise = WR & ~wr_q`.
  - `rd_q` and `wr_q` reset to 1, so a button held through reset issues no request.
- FSM states:
  - IDLE: accepts requests.
  - WR_EXEC: asserts RAM write.
  - RD_WAIT: counts RAM read latency.
  - REJECT: one cycle, no RAM access.
- In IDLE, exactly one rise → accept. Latch `A` and `DIn`, clear `Done` and `Err`, set `Busy`.
- Both rises in the same cycle → accept as collision → REJECT.
- `A` ≥ `DEPTH` → accept → REJECT; no RAM access.
- WR_EXEC: RAM port A write enable high for exactly one cycle, address and data from the latched values. Then set `Done`, clear `Busy`, return to IDLE.
- RD_WAIT: RAM port B address = latched address. A counter loads `RD_LAT` and decrements. At zero: `DOut` ← RAM q, set `Done`, clear `Busy`, return to IDLE.
- REJECT: set `Done` and `Err`, clear `Busy`, return to IDLE. `DOut` is unchanged.
- Rises seen outside IDLE are discarded. The edge registers still track, so a held button never retriggers.
- RAM write enable is decoded combinationally from state == WR_EXEC. Reset therefore removes it immediately.

## Timing
- Accept edge = edge T.
- Write: RAM write occurs at edge T+1; `Done`=1 and `Busy`=0 after edge T+2.
- Read: `DOut` valid and `Done`=1 after edge T+1+`RD_LAT`.
- Reject: `Done`=`Err`=1 after edge T+1.
- Minimum request spacing: a rise is accepted in the first cycle in which the FSM is IDLE.
- Reset values: `DOut`=0, `Done`=0, `Busy`=0, `Err`=0, state IDLE, counter 0.
- Reset during WR_EXEC: the word at the latched address is undefined afterwards. The bench must not check it.
- Reset during a read: the read is aborted; `DOut` returns to 0.
- RAM contents are never cleared by reset.

## Structure
- Package `dpram_pkg`:
  - FSM state encoding.
  - Default `ADDR_W`/`DATA_W`/`DEPTH`/`RD_LAT`.
  - Reject-cause constants for debug.
- Sub-module `dpram_core`: the inferred true dual-port RAM.
  - Port A write-only, port B read-only.
  - Output register pipeline of `RD_LAT` stages.
  - Same clock as the controller.
  - No reset on the array.

## Test plan
- Reset, then WR rise with A=0x005, DIn=0xBEEF; then RD rise with A=0x005:
  - Write: `Done`=1 two edges after accept.
  - Read: `DOut`=0xBEEF `RD_LAT`+1 edges after accept.
- RD and WR rise in the same cycle with A=0x010:
  - `Err`=1 and `Done`=1 one edge after accept.
  - Memory at 0x010 unchanged; `DOut` unchanged.
- `DEPTH`=768, WR to A=0x300:
  - `Err`=1; a subsequent read of 0x000 returns its prior value.
- WR held high for 50 cycles with A=0x020, DIn=0x1234:
  - Exactly one write is performed.
  - Second rise while `Busy` is dropped: `Done` pulses only once.
- Assert `ar` during RD_WAIT:
  - `DOut`=`Done`=`Busy`=0 immediately.
  - RD held through reset release produces no access.
- Write 0xA5A5 to addresses 0x000, 0x3FF, and 0x200, then read each back for `RD_LAT`=1, 2, 3:
  - Each read returns 0xA5A5 with the latencies above.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants for the dual-port RAM access sequencer: default geometry,
// FSM state encoding and reject-cause codes.
package dpram_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 1024;
  localparam int RD_LAT_DEF = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_EXEC = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_REJECT  = 2'd3;

  localparam logic [1:0] CAUSE_NONE      = 2'd0;
  localparam logic [1:0] CAUSE_COLLISION = 2'd1;
  localparam logic [1:0] CAUSE_RANGE     = 2'd2;

  // A simultaneous read/write rise outranks a bad address.
  function automatic logic [1:0] reject_cause(input logic rd_rise,
                                              input logic wr_rise,
                                              input logic out_of_range);
    if (rd_rise && wr_rise) return CAUSE_COLLISION;
    if (out_of_range)       return CAUSE_RANGE;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/dpram_core.sv
// Inferred true dual-port RAM: port A write-only, port B read-only with an
// RD_LAT-deep output register pipeline.
module dpram_core #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] d_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] pipe [RD_LAT];

  // NOTE: the array and read pipeline carry no reset so they map onto block RAM;
  // contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= d_a;
  end

  always_ff @(posedge clk) begin
    pipe[0] <= mem[addr_b];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign q_b = pipe[RD_LAT-1];

endmodule

// File: rtl/dpram_access_ctrl.sv
// Edge-triggered read/write sequencer between the switch/button front end and
// the on-chip dual-port RAM; one access in flight, extra requests dropped.
module dpram_access_ctrl
  import dpram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              ar,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DIn,
  input  logic              RD,
  input  logic              WR,
  output logic [DATA_W-1:0] DOut,
  output logic              Done,
  output logic              Busy,
  output logic              Err
);

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rd_rise, wr_rise, out_of_range, ram_we;
  logic [1:0]        cause;
  logic [DATA_W-1:0] ram_q;

  assign rd_rise      = RD & ~rd_q;
  assign wr_rise      = WR & ~wr_q;
  assign out_of_range = (32'(A) >= DEPTH);
  assign cause        = reject_cause(rd_rise, wr_rise, out_of_range);
  // The write strobe lives in the first WR_EXEC cycle only, so reset kills it at once.
  assign ram_we       = (state == ST_WR_EXEC) && (cnt != 2'd0);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      rd_q   <= 1'b1;
      wr_q   <= 1'b1;
      state  <= ST_IDLE;
      cnt    <= 2'd0;
      addr_q <= '0;
      data_q <= '0;
      DOut   <= '0;
      Done   <= 1'b0;
      Busy   <= 1'b0;
      Err    <= 1'b0;
    end else begin
      rd_q <= RD;
      wr_q <= WR;
      case (state)
        ST_IDLE: begin
          if (rd_rise || wr_rise) begin
            addr_q <= A;
            data_q <= DIn;
            Done   <= 1'b0;
            Err    <= 1'b0;
            Busy   <= 1'b1;
            if (cause != CAUSE_NONE) begin
              state <= ST_REJECT;
            end else if (wr_rise) begin
              state <= ST_WR_EXEC;
              cnt   <= 2'd1;
            end else begin
              state <= ST_RD_WAIT;
              cnt   <= 2'(RD_LAT);
            end
          end
        end
        ST_WR_EXEC: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            DOut  <= ram_q;
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          Done  <= 1'b1;
          Err   <= 1'b1;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  dpram_core #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .RD_LAT(RD_LAT)
  ) u_core (
    .clk   (clk),
    .we_a  (ram_we),
    .addr_a(addr_q),
    .d_a   (data_q),
    .addr_b(addr_q),
    .q_b   (ram_q)
  );

endmodule
